// File: rtl/neopixel_receiver.sv
// WS2812 line decoder: classifies high-pulse widths into bits, packs MSB-first bytes, writes them to ascending buffer addresses.
// Latency: pin edges seen 3 cycles late; byte strobe the cycle after the 8th falling edge; frame_done after RST_DET_TCK low samples.
// No backpressure: the line cannot be stalled, so every strobe must be accepted by the buffer when it is issued.
module neopixel_receiver #(
    parameter int LEDS           = 200,
    parameter int CLK_HZ         = 50_000_000,
    parameter int MIN_HI_TCK     = 5,
    parameter int BIT_THRESH_TCK = 22,
    parameter int MAX_HI_TCK     = 60,
    parameter int RST_DET_TCK    = 2000,
    localparam int DEPTH         = LEDS * 3,
    localparam int AW            = $clog2(DEPTH),
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_din,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic [7:0]    o_wr_data,
    output logic          o_busy,
    output logic          o_frame_done,
    output logic [CW-1:0] o_byte_count,
    output logic          o_err,
    output logic          o_overflow
);

    localparam logic [1:0] ST_SYNC = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_LO   = 2'd3;

    localparam logic [15:0]   MIN_C    = 16'(MIN_HI_TCK);
    localparam logic [15:0]   THRESH_C = 16'(BIT_THRESH_TCK);
    localparam logic [15:0]   MAX_C    = 16'(MAX_HI_TCK);
    localparam logic [15:0]   RST_C    = 16'(RST_DET_TCK);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam int            CLK_KHZ  = CLK_HZ / 1000;

    logic          din_s1;
    logic          din_s2;
    logic          din_q;
    logic          rise;
    logic          fall;
    logic [1:0]    state;
    logic [15:0]   cnt;
    logic [15:0]   cnt_inc;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;
    logic [CW-1:0] addr;
    logic          bit_val;
    logic [7:0]    byte_nxt;
    logic          clk_ok;

    // Tick constants are precomputed for the nominal clock; the rate itself only sanity-gates nothing.
    assign clk_ok = (CLK_KHZ >= 0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
            din_q  <= 1'b0;
        end else begin
            din_s1 <= i_din;
            din_s2 <= din_s1;
            din_q  <= din_s2;
        end
    end

    assign rise     = din_s2 & ~din_q;
    assign fall     = ~din_s2 & din_q;
    assign cnt_inc  = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign bit_val  = (cnt >= THRESH_C);
    assign byte_nxt = {shift_q[6:0], bit_val};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_SYNC;
            cnt          <= 16'd0;
            bit_cnt      <= 3'd0;
            shift_q      <= 8'd0;
            addr         <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= 8'd0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_byte_count <= '0;
            o_err        <= 1'b0;
            o_overflow   <= 1'b0;
        end else begin
            o_wr_en      <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                ST_SYNC: begin
                    // Only a full latch gap proves we are between frames.
                    if (din_s2) begin
                        cnt <= 16'd0;
                    end else if (clk_ok && cnt_inc >= RST_C) begin
                        cnt   <= 16'd0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_IDLE: begin
                    if (rise) begin
                        state      <= ST_HI;
                        cnt        <= 16'd1;
                        o_busy     <= 1'b1;
                        bit_cnt    <= 3'd0;
                        addr       <= '0;
                        o_err      <= 1'b0;
                        o_overflow <= 1'b0;
                    end
                end
                ST_HI: begin
                    if (fall) begin
                        state <= ST_LO;
                        cnt   <= 16'd1;
                        if (cnt < MIN_C) begin
                            o_err <= 1'b1;
                        end else begin
                            shift_q <= byte_nxt;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (addr == DEPTH_C) begin
                                    o_overflow <= 1'b1;
                                end else begin
                                    o_wr_en   <= 1'b1;
                                    o_wr_data <= byte_nxt;
                                    o_wr_addr <= addr[AW-1:0];
                                    addr      <= addr + 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end else if (cnt_inc >= MAX_C) begin
                        // Stuck-high line: abandon the frame and wait for a clean gap.
                        o_err        <= 1'b1;
                        o_busy       <= 1'b0;
                        o_frame_done <= 1'b1;
                        cnt          <= 16'd0;
                        state        <= ST_SYNC;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    if (rise) begin
                        state <= ST_HI;
                        cnt   <= 16'd1;
                    end else if (cnt_inc >= RST_C) begin
                        if (bit_cnt != 3'd0) begin
                            o_err <= 1'b1;
                        end
                        bit_cnt      <= 3'd0;
                        o_byte_count <= addr;
                        o_frame_done <= 1'b1;
                        o_busy       <= 1'b0;
                        cnt          <= 16'd0;
                        state        <= ST_IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neopixel_receiver.sv
// Directed bench for neopixel_receiver with a 4-pixel frame (12-byte buffer) to keep runs short.
module tb_neopixel_receiver;

    localparam int TL    = 4;
    localparam int DEPTH = TL * 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          din;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] byte_count;
    logic          err;
    logic          overflow;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    int fall_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int overlap  = 0;
    logic [7:0] cap_data[$];
    int         cap_addr[$];

    neopixel_receiver #(.LEDS(TL)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_data    (wr_data),
        .o_busy       (busy),
        .o_frame_done (frame_done),
        .o_byte_count (byte_count),
        .o_err        (err),
        .o_overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            cap_data.push_back(wr_data);
            cap_addr.push_back(int'(wr_addr));
        end
        if (frame_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (wr_en && frame_done) overlap <= overlap + 1;
    end

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            hold(1'b1, 30);
            fall_cyc = cyc;
            hold(1'b0, 30);
        end else begin
            hold(1'b1, 15);
            fall_cyc = cyc;
            hold(1'b0, 45);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic test_reset;
        logic [31:0] outs;
        rst_n = 1'b0;
        din   = 1'b0;
        repeat (4) @(negedge clk);
        outs = {wr_en, 4'(wr_addr), wr_data, busy, frame_done, 4'(byte_count), err, overflow};
        nvec++;
        if (outs !== 32'd0) begin
            nmis++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_byte;
        int s = cap_data.size();
        int d = done_cnt;
        hold(1'b0, 2500);
        send_bit(1'b1);
        nvec++;
        if (busy !== 1'b1) begin nmis++; $display("FAIL single_busy: got %b want 1", busy); end
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        hold(1'b0, 2500);
        nvec++;
        if (cap_data.size() - s !== 1) begin
            nmis++; $display("FAIL single_strobes: got %0d want 1", cap_data.size() - s);
        end else begin
            nvec++;
            if (cap_addr[s] !== 0) begin nmis++; $display("FAIL single_addr: got %0d want 0", cap_addr[s]); end
            nvec++;
            if (cap_data[s] !== 8'hA5) begin nmis++; $display("FAIL single_data: got %h want a5", cap_data[s]); end
        end
        nvec++;
        if (done_cnt - d !== 1) begin nmis++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - d); end
        nvec++;
        if (done_cyc - fall_cyc < 1999 || done_cyc - fall_cyc > 2005) begin
            nmis++; $display("FAIL single_done_delay: got %0d want 1999..2005", done_cyc - fall_cyc);
        end
        nvec++;
        if (byte_count !== CW'(1)) begin nmis++; $display("FAIL single_count: got %0d want 1", byte_count); end
        nvec++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            nmis++; $display("FAIL single_err_busy: got err=%b busy=%b want 0 0", err, busy);
        end
    endtask

    task automatic test_full_frame;
        int s = cap_data.size();
        for (int a = 0; a < DEPTH; a++) send_byte(8'(a) ^ 8'h3C);
        hold(1'b0, 2500);
        nvec++;
        if (cap_data.size() - s !== DEPTH) begin
            nmis++; $display("FAIL full_strobes: got %0d want %0d", cap_data.size() - s, DEPTH);
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                nvec++;
                if (cap_addr[s+a] !== a || cap_data[s+a] !== (8'(a) ^ 8'h3C)) begin
                    nmis++;
                    $display("FAIL full_byte%0d: got addr %0d data %h want addr %0d data %h",
                             a, cap_addr[s+a], cap_data[s+a], a, 8'(a) ^ 8'h3C);
                end
            end
        end
        nvec++;
        if (byte_count !== CW'(DEPTH)) begin nmis++; $display("FAIL full_count: got %0d want %0d", byte_count, DEPTH); end
        nvec++;
        if (overflow !== 1'b0 || err !== 1'b0) begin
            nmis++; $display("FAIL full_flags: got ovf=%b err=%b want 0 0", overflow, err);
        end
    endtask

    task automatic test_overflow;
        int s = cap_data.size();
        for (int a = 0; a <= DEPTH; a++) send_byte(8'(a) ^ 8'h3C);
        hold(1'b0, 2500);
        nvec++;
        if (cap_data.size() - s !== DEPTH) begin
            nmis++; $display("FAIL ovf_strobes: got %0d want %0d", cap_data.size() - s, DEPTH);
        end
        nvec++;
        if (overflow !== 1'b1) begin nmis++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        nvec++;
        if (byte_count !== CW'(DEPTH)) begin nmis++; $display("FAIL ovf_count: got %0d want %0d", byte_count, DEPTH); end
    endtask

    task automatic test_glitch;
        int s = cap_data.size();
        hold(1'b1, 15);
        nvec++;
        if (overflow !== 1'b0 || busy !== 1'b1) begin
            nmis++; $display("FAIL glitch_frame_start: got ovf=%b busy=%b want 0 1", overflow, busy);
        end
        hold(1'b0, 45);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        hold(1'b1, 3);
        hold(1'b0, 30);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        hold(1'b0, 2500);
        nvec++;
        if (err !== 1'b1) begin nmis++; $display("FAIL glitch_err: got %b want 1", err); end
        nvec++;
        if (cap_data.size() - s !== 1) begin
            nmis++; $display("FAIL glitch_strobes: got %0d want 1", cap_data.size() - s);
        end else begin
            nvec++;
            if (cap_data[s] !== 8'h5A || cap_addr[s] !== 0) begin
                nmis++; $display("FAIL glitch_byte: got addr %0d data %h want addr 0 data 5a", cap_addr[s], cap_data[s]);
            end
        end
    endtask

    task automatic test_partial;
        int s = cap_data.size();
        int d = done_cnt;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        hold(1'b0, 2500);
        nvec++;
        if (cap_data.size() - s !== 0) begin nmis++; $display("FAIL partial_strobes: got %0d want 0", cap_data.size() - s); end
        nvec++;
        if (err !== 1'b1) begin nmis++; $display("FAIL partial_err: got %b want 1", err); end
        nvec++;
        if (done_cnt - d !== 1) begin nmis++; $display("FAIL partial_done: got %0d want 1", done_cnt - d); end
        nvec++;
        if (byte_count !== CW'(0)) begin nmis++; $display("FAIL partial_count: got %0d want 0", byte_count); end
    endtask

    task automatic test_stuck;
        int s = cap_data.size();
        int d = done_cnt;
        hold(1'b1, 50);
        nvec++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            nmis++; $display("FAIL stuck_before: got err=%b busy=%b want 0 1", err, busy);
        end
        hold(1'b1, 20);
        nvec++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            nmis++; $display("FAIL stuck_after: got err=%b busy=%b want 1 0", err, busy);
        end
        hold(1'b1, 30);
        nvec++;
        if (done_cnt - d !== 1) begin nmis++; $display("FAIL stuck_done: got %0d want 1", done_cnt - d); end
        hold(1'b0, 500);
        send_byte(8'h81);
        hold(1'b0, 2500);
        nvec++;
        if (cap_data.size() - s !== 0) begin nmis++; $display("FAIL stuck_resync: got %0d strobes want 0", cap_data.size() - s); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] outs;
        int s;
        int d;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        nvec++;
        if (busy !== 1'b1) begin nmis++; $display("FAIL midrst_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        outs = {wr_en, 4'(wr_addr), wr_data, busy, frame_done, 4'(byte_count), err, overflow};
        nvec++;
        if (outs !== 32'd0) begin nmis++; $display("FAIL midrst_outputs: got %h want 0", outs); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        s = cap_data.size();
        d = done_cnt;
        send_byte(8'hFF);
        send_byte(8'h96);
        nvec++;
        if (cap_data.size() - s !== 0) begin nmis++; $display("FAIL midrst_nosync: got %0d strobes want 0", cap_data.size() - s); end
        hold(1'b0, 2500);
        send_byte(8'hC3);
        hold(1'b0, 2500);
        nvec++;
        if (cap_data.size() - s !== 1) begin
            nmis++; $display("FAIL midrst_strobes: got %0d want 1", cap_data.size() - s);
        end else begin
            nvec++;
            if (cap_data[s] !== 8'hC3 || cap_addr[s] !== 0) begin
                nmis++; $display("FAIL midrst_byte: got addr %0d data %h want addr 0 data c3", cap_addr[s], cap_data[s]);
            end
        end
        nvec++;
        if (done_cnt - d !== 1) begin nmis++; $display("FAIL midrst_done: got %0d want 1", done_cnt - d); end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_full_frame;
        test_overflow;
        test_glitch;
        test_partial;
        test_stuck;
        test_reset_mid;
        nvec++;
        if (overlap !== 0) begin nmis++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/neopixel_receiver.md
Name: neopixel_receiver

Overview:
- Single-wire WS2812/NeoPixel stream decoder; the receive end of the NeoPixel driver link.
- Classifies each bit by measuring its high-pulse width, assembles MSB-first bytes and writes them to a byte-wide buffer at ascending addresses.
- Detects the reset (latch) gap as end of frame and reports framing errors.
- Used for loopback verification of the transmitter and as a pixel-data input for chained boards.

Parameters:
- LEDS, 200, pixels per frame; buffer depth is LEDS*3 bytes.
- CLK_HZ, 50_000_000, clock frequency, informational only; the tick constants below are precomputed for 50 MHz.
- MIN_HI_TCK, 5, high pulses shorter than this are glitches (100 ns).
- BIT_THRESH_TCK, 22, high pulse ≥ this decodes as 1, otherwise 0 (440 ns).
- MAX_HI_TCK, 60, high pulse reaching this is a stuck-line error (1.2 us).
- RST_DET_TCK, 2000, continuous low of this length is end of frame (40 us).

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_din, in, 1, NeoPixel line input; asynchronous to i_clk.
- o_wr_en, out, 1, one-cycle write strobe.
- o_wr_addr, out, $clog2(LEDS*3), byte address, 0..LEDS*3-1.
- o_wr_data, out, 8, decoded byte, MSB first.
- o_busy, out, 1, high from first rising edge of a frame until end of frame.
- o_frame_done, out, 1, one-cycle pulse at end of frame.
- o_byte_count, out, $clog2(LEDS*3+1), bytes written in the last completed frame.
- o_err, out, 1, sticky framing error; cleared at next frame start.
- o_overflow, out, 1, sticky flag, frame exceeded LEDS*3 bytes; cleared at next frame start.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state SYNC, all counters 0.
- Input path:
  - i_din passes a 2-flop synchronizer, then a registered copy for edge detection.
  - Rise/fall are detected 3 cycles after the pin change.
  - All timing counts are in synchronized-sample cycles.
- Pulse counter is 16 bits and saturates at 0xFFFF.
- State SYNC:
  - Waits for RST_DET_TCK consecutive low samples, then goes to IDLE.
  - Any high sample restarts the count.
  - Prevents starting decode mid-frame.
- State IDLE:
  - On rising edge: go to HI, cnt=1, o_busy=1, bit_cnt=0, byte address=0.
  - Same edge clears o_err and o_overflow.
- State HI (increment cnt each cycle while high):
  - Falling edge with cnt < MIN_HI_TCK: set o_err, discard the bit, go to LO.
  - Falling edge with cnt ≥ MIN_HI_TCK: bit = (cnt ≥ BIT_THRESH_TCK). Shift the bit into the LSB of shift reg, bit_cnt++, go to LO with cnt=1.
  - On the 8th bit: o_wr_en=1 in the cycle after the falling edge, o_wr_data = assembled byte, o_wr_addr = current address. Then address++ and bit_cnt=0.
  - If the address already equals LEDS*3: no write, set o_overflow; the address stays saturated.
  - cnt reaches MAX_HI_TCK: set o_err, o_busy=0, o_frame_done pulse, go to SYNC.
- State LO:
  - Rising edge: go to HI, cnt=1. Low-width is not checked.
  - cnt reaches RST_DET_TCK: end of frame.
    - If bit_cnt ≠ 0, discard the partial byte and set o_err.
    - o_byte_count = bytes written; o_frame_done=1 for one cycle; o_busy=0; go to IDLE.
- o_wr_en and o_frame_done never coincide: the last write precedes the gap by ≥ RST_DET_TCK cycles.
- o_wr_addr and o_wr_data hold their values between strobes.
- Reset mid-frame: outputs clear immediately. After release the block resynchronises via SYNC; no writes until a full gap is seen.

Test Plan:
- Single byte: reset, 2500 low, byte 0xA5 (1: 30 hi/30 lo, 0: 15 hi/45 lo), 2500 low -> one o_wr_en, addr 0, data 0xA5; o_frame_done one cycle, ~2000 cycles after last fall; o_byte_count=1; o_err=0.
- Full frame: 600 bytes with data = addr[7:0] ^ 0x3C, then gap -> 600 strobes, addr 0..599 ascending, data matches; o_byte_count=600; o_overflow=0.
- Overflow: 601 bytes -> 600 strobes, no strobe for byte 601; o_overflow=1, o_byte_count=600. Next frame's first rising edge clears o_overflow.
- Glitch: 3-cycle high pulse inside a byte -> o_err=1, bit ignored. The rest of the byte decodes correctly if 8 valid bits follow.
- Partial and stuck cases:
  - 5 bits then gap -> no strobe, o_err=1, o_frame_done pulses, o_byte_count=0.
  - Line held high 100 cycles -> o_err=1 at cycle 60, state SYNC.
- Reset mid-byte: assert i_rst_n low after 4 bits -> all outputs 0 at once. Release with line toggling -> no strobes until 2000 consecutive low cycles; the next full byte then decodes at addr 0.
